// File: rtl/hdmi_pkg.sv
// Shared constants, control-bundle type and colour helper for the HDMI scan-out path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hdmi_pkg;

    // 640x480@60 timing, pixel-clock units and lines
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Sync pulses are active-low for this mode
    localparam logic VGA_SYNC_POL = 1'b0;

    // 4x upscale: 160x120 framebuffer
    localparam int VGA_SCALE_SHIFT = 2;

    // Colour formats
    localparam int RGB332_W = 8;
    localparam int RGB888_W = 24;
    localparam int CHAN_W   = 8;

    // VRAM port B address width
    localparam int VRAM_AW = 16;

    // Timing flags that travel alongside the pixel data through the pipe
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
    } vid_ctl_t;

    // Bit-replicating expansion so full-scale codes map to 0xFF
    function automatic logic [RGB888_W-1:0] rgb332_to_rgb888(input logic [RGB332_W-1:0] d);
        return {d[7:5], d[7:5], d[7:6],
                d[4:2], d[4:2], d[4:3],
                d[1:0], d[1:0], d[1:0], d[1:0]};
    endfunction

endpackage

// File: rtl/hdmi_timing_gen.sv
// Horizontal/vertical raster counters with active, sync and wrap decodes.
// Latency: counters are stage-0 state; all decodes are combinational from them.
// Backpressure: none; free-runs while i_enable=1, parked at (0,0) otherwise.
module hdmi_timing_gen
    import hdmi_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = VGA_SYNC_POL,
    parameter int   HW       = 10,
    parameter int   VW       = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_enable,
    output logic [HW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_active,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_origin,
    output logic          o_line_end,
    output logic          o_frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_line_end;
    logic          w_frame_end;

    assign w_line_end  = (r_h_cnt == H_LAST);
    assign w_frame_end = w_line_end && (r_v_cnt == V_LAST);

    // Raster position; reset and disable both park it at the frame origin
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_enable) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_line_end) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_frame_end ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign o_h_cnt     = r_h_cnt;
    assign o_v_cnt     = r_v_cnt;
    assign o_active    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign o_hs        = ((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
    assign o_vs        = ((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
    assign o_origin    = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign o_line_end  = w_line_end;
    assign o_frame_end = w_frame_end;

endmodule

// File: rtl/hdmi_scanout.sv
// Scan-out engine: raster timing, upscaled VRAM addressing and RGB332->RGB888 expansion.
// Latency: 3 clk from counter state to every output; all outputs stay mutually aligned.
// Backpressure: none; VRAM port B is read-only with fixed 1-clk latency. The RAM wrapper
// ties web=0, dinb=0 and clkb=clk, so only enb/addrb/doutb appear here.
module hdmi_scanout
    import hdmi_pkg::*;
#(
    parameter int   H_ACTIVE    = VGA_H_ACTIVE,
    parameter int   H_FP        = VGA_H_FP,
    parameter int   H_SYNC      = VGA_H_SYNC,
    parameter int   H_BP        = VGA_H_BP,
    parameter int   V_ACTIVE    = VGA_V_ACTIVE,
    parameter int   V_FP        = VGA_V_FP,
    parameter int   V_SYNC      = VGA_V_SYNC,
    parameter int   V_BP        = VGA_V_BP,
    parameter logic SYNC_POL    = VGA_SYNC_POL,
    parameter int   SCALE_SHIFT = VGA_SCALE_SHIFT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    output logic                vram_en,
    output logic [VRAM_AW-1:0]  vram_addr,
    input  logic [RGB332_W-1:0] vram_dout,
    output logic                hsync,
    output logic                vsync,
    output logic                de,
    output logic [CHAN_W-1:0]   red,
    output logic [CHAN_W-1:0]   green,
    output logic [CHAN_W-1:0]   blue,
    output logic                frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [VRAM_AW-1:0] FB_W   = VRAM_AW'(H_ACTIVE >> SCALE_SHIFT);
    localparam logic [VW-1:0]      V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW:0]        V_MASK = (VW+1)'((1 << SCALE_SHIFT) - 1);

    localparam vid_ctl_t CTL_IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, de: 1'b0, fs: 1'b0};

    // Stage 0: raster counters and decodes
    logic [HW-1:0] w_h_cnt;
    logic [VW-1:0] w_v_cnt;
    logic          w_active;
    logic          w_hs;
    logic          w_vs;
    logic          w_origin;
    logic          w_line_end;
    logic          w_frame_end;

    hdmi_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_enable    (enable),
        .o_h_cnt     (w_h_cnt),
        .o_v_cnt     (w_v_cnt),
        .o_active    (w_active),
        .o_hs        (w_hs),
        .o_vs        (w_vs),
        .o_origin    (w_origin),
        .o_line_end  (w_line_end),
        .o_frame_end (w_frame_end)
    );

    // Either reset or disable forces every stage idle; reset wins only in the
    // sense that both paths load identical values.
    logic w_idle;
    assign w_idle = !rst_n || !enable;

    // Row base tracks fb_row*FB_W incrementally so no multiplier is needed.
    // It advances after the last of each group of 2**SCALE_SHIFT repeated lines.
    logic [VRAM_AW-1:0] r_row_base;
    logic [VW:0]        w_v_next;
    logic               w_row_step;
    logic [VRAM_AW-1:0] w_addr0;

    assign w_v_next   = {1'b0, w_v_cnt} + (VW+1)'(1);
    assign w_row_step = (w_v_cnt < V_ACT) && ((w_v_next & V_MASK) == '0);
    assign w_addr0    = r_row_base + VRAM_AW'(w_h_cnt >> SCALE_SHIFT);

    // Row base update at each line wrap; cleared on frame wrap
    always_ff @(posedge clk) begin
        if (w_idle) begin
            r_row_base <= '0;
        end else if (w_line_end) begin
            if (w_frame_end) begin
                r_row_base <= '0;
            end else if (w_row_step) begin
                r_row_base <= r_row_base + FB_W;
            end
        end
    end

    // Stage 1: issue the VRAM read; address holds through blanking
    logic               r_vram_en;
    logic [VRAM_AW-1:0] r_vram_addr;

    always_ff @(posedge clk) begin
        if (w_idle) begin
            r_vram_en   <= 1'b0;
            r_vram_addr <= '0;
        end else begin
            r_vram_en <= w_active;
            if (w_active) begin
                r_vram_addr <= w_addr0;
            end
        end
    end

    assign vram_en   = r_vram_en;
    assign vram_addr = r_vram_addr;

    // Timing flags ride two registers so they land with the RAM data at stage 3
    vid_ctl_t r_ctl1;
    vid_ctl_t r_ctl2;

    // Stages 1-2 of the flag delay line
    always_ff @(posedge clk) begin
        if (w_idle) begin
            r_ctl1 <= CTL_IDLE;
            r_ctl2 <= CTL_IDLE;
        end else begin
            r_ctl1 <= '{hs: w_hs, vs: w_vs, de: w_active, fs: w_origin};
            r_ctl2 <= r_ctl1;
        end
    end

    // Stage 3: registered outputs; colour is blanked outside the active area
    logic                r_hsync;
    logic                r_vsync;
    logic                r_de;
    logic                r_fs;
    logic [RGB888_W-1:0] r_rgb;

    always_ff @(posedge clk) begin
        if (w_idle) begin
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
            r_de    <= 1'b0;
            r_fs    <= 1'b0;
            r_rgb   <= '0;
        end else begin
            r_hsync <= r_ctl2.hs;
            r_vsync <= r_ctl2.vs;
            r_de    <= r_ctl2.de;
            r_fs    <= r_ctl2.fs;
            r_rgb   <= r_ctl2.de ? rgb332_to_rgb888(vram_dout) : '0;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign frame_start = r_fs;
    assign red         = r_rgb[23:16];
    assign green       = r_rgb[15:8];
    assign blue        = r_rgb[7:0];

endmodule

// File: tb/tb_hdmi_scanout.sv
// Bench for hdmi_scanout: full-width lines, shortened vertical blanking/active
// region so two frames plus an enable abort fit a short run. Random VRAM image
// checked every clock against a position-based reference model.
module tb_hdmi_scanout;

    localparam int HA = 640, HFP = 16, HS = 96, HBP = 48;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VA = 16, VFP = 2, VS = 2, VBP = 2;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int SH = 2;
    localparam int FBW = HA >> SH;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        vram_en;
    logic [15:0] vram_addr;
    logic [7:0]  vram_dout;
    logic        hsync, vsync, de, frame_start;
    logic [7:0]  red, green, blue;

    always #5 clk = ~clk;

    hdmi_scanout #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .SYNC_POL (1'b0), .SCALE_SHIFT (SH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .vram_en     (vram_en),
        .vram_addr   (vram_addr),
        .vram_dout   (vram_dout),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_start (frame_start)
    );

    // VRAM port B model: 1-clk registered read
    logic [7:0] mem [0:65535];
    logic [7:0] ram_q;
    always @(posedge clk) if (vram_en) ram_q <= mem[vram_addr];
    assign vram_dout = ram_q;

    int vectors, miscompares;
    int cyc, k0, kl, fs_n;
    int pos0, pos1, pos2, pos3;
    bit idl0, idl1, idl2;
    int exp_addr;
    logic prev_de, prev_hs, prev_vs;
    int de_rise[$], de_fall[$], hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], fs_q[$];

    // Reference rules, from raster position p = v*HT + h
    function automatic bit is_act(input int p);
        return ((p % HT) < HA) && ((p / HT) < VA);
    endfunction
    function automatic int fb_addr(input int p);
        return ((p / HT) >> SH) * FBW + ((p % HT) >> SH);
    endfunction
    function automatic bit in_hs(input int p);
        return ((p % HT) >= HA + HFP) && ((p % HT) < HA + HFP + HS);
    endfunction
    function automatic bit in_vs(input int p);
        return ((p / HT) >= VA + VFP) && ((p / HT) < VA + VFP + VS);
    endfunction
    function automatic logic [23:0] expand(input logic [7:0] d);
        return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], d[1:0], d[1:0], d[1:0], d[1:0]};
    endfunction
    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: advance the model on the edge, compare at the falling edge
    task automatic step();
        logic [27:0] eo;
        bit          de_e;
        int          h, v;
        @(posedge clk);
        cyc++;
        pos3 = pos2; pos2 = pos1; pos1 = pos0;
        idl2 = idl1; idl1 = idl0;
        idl0 = !(rst_n && enable);
        pos0 = idl0 ? 0 : (pos1 + 1) % FRAME;
        if (idl0) exp_addr = 0;
        else if (is_act(pos1)) exp_addr = fb_addr(pos1);
        @(negedge clk);
        check("vram_en", vram_en, !idl0 && is_act(pos1));
        check("vram_addr", vram_addr, exp_addr);
        if (idl0 || idl1 || idl2) begin
            eo = {1'b1, 1'b1, 1'b0, 1'b0, 24'h0};
        end else begin
            de_e = is_act(pos3);
            eo = {!in_hs(pos3), !in_vs(pos3), de_e, pos3 == 0,
                  de_e ? expand(mem[fb_addr(pos3)]) : 24'h0};
        end
        check("video", {hsync, vsync, de, frame_start, red, green, blue}, eo);
        if (!idl0) begin
            h = pos1 % HT; v = pos1 / HT;
            if (v == 0 && (h == 0 || h == 3)) check("addr_h0_3", vram_addr, 0);
            if (v == 0 && h == 4)             check("addr_h4", vram_addr, 1);
            if (v == 0 && h == 636)           check("addr_h636", vram_addr, 159);
            if (v == 3 && h == 0)             check("addr_line3", vram_addr, 0);
            if (v == 4 && h == 0)             check("addr_line4", vram_addr, 160);
            if (v == VA - 1 && h == HA - 1)   check("addr_last", vram_addr, (VA / 4 - 1) * 160 + 159);
        end
        if (!(idl0 || idl1 || idl2) && (pos3 / HT) == 0) begin
            h = pos3 % HT;
            if (h == 0)  check("rgb_E0", {red, green, blue}, 24'hFF0000);
            if (h == 4)  check("rgb_1C", {red, green, blue}, 24'h00FF00);
            if (h == 8)  check("rgb_03", {red, green, blue}, 24'h0000FF);
            if (h == 12) check("rgb_49", {red, green, blue}, 24'h494955);
        end
        if (de && !prev_de) de_rise.push_back(cyc);
        if (!de && prev_de) de_fall.push_back(cyc);
        if (!hsync && prev_hs) hs_fall.push_back(cyc);
        if (hsync && !prev_hs) hs_rise.push_back(cyc);
        if (!vsync && prev_vs) vs_fall.push_back(cyc);
        if (vsync && !prev_vs) vs_rise.push_back(cyc);
        if (frame_start === 1'b1) fs_q.push_back(cyc);
        prev_de = de; prev_hs = hsync; prev_vs = vsync;
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        pos0 = 0; pos1 = 0; pos2 = 0; pos3 = 0;
        idl0 = 1'b1; idl1 = 1'b1; idl2 = 1'b1;
        exp_addr = 0;
        prev_de = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        mem[0] = 8'hE0; mem[1] = 8'h1C; mem[2] = 8'h03; mem[3] = 8'h49;

        // Reset for 5 clocks
        rst_n = 1'b0; enable = 1'b1;
        repeat (5) step();
        check("rst_sync", {hsync, vsync}, 2'b11);
        check("rst_de_rgb_fs", {de, red, green, blue, frame_start}, 0);
        check("rst_vram", {vram_en, vram_addr}, 0);
        k0 = cyc;

        // Release: one full frame, then into frame 2 up to line 10, h=200
        rst_n = 1'b1;
        repeat (FRAME + 10 * HT + 200) step();
        check("latency_de", qat(de_rise, 0) - k0, 3);
        check("latency_fs", qat(fs_q, 0) - k0, 3);
        check("de_width", qat(de_fall, 0) - qat(de_rise, 0), HA);
        check("hs_start", qat(hs_fall, 0) - qat(de_rise, 0), HA + HFP);
        check("hs_width", qat(hs_rise, 0) - qat(hs_fall, 0), HS);
        check("vs_start", qat(vs_fall, 0) - qat(fs_q, 0), (VA + VFP) * HT);
        check("vs_width", qat(vs_rise, 0) - qat(vs_fall, 0), VS * HT);
        check("frame_period", qat(fs_q, 1) - qat(fs_q, 0), FRAME);

        // Enable abort for 10 clocks
        enable = 1'b0;
        step();
        check("abort_de", de, 1'b0);
        check("abort_sync", {hsync, vsync}, 2'b11);
        repeat (9) step();
        kl = cyc;
        fs_n = fs_q.size();
        enable = 1'b1;
        repeat (2 * HT) step();
        check("restart_fs", qat(fs_q, fs_n) - kl, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
